// File: rtl/hdr_frame_sequencer.sv
// Sequences one HDR-DDR CCC transfer (command word, N data words, CRC word) and
// drives frame-counter enable, bit index and toggle strobes from registered state.
module hdr_frame_sequencer #(
  parameter int WORD_BITS = 20,
  parameter int CRC_BITS  = 10
) (
  input  logic       i_fseq_clk,
  input  logic       i_fseq_rst_n,
  input  logic       i_fseq_start,
  input  logic       i_fseq_abort,
  input  logic       i_scl_pos_edge,
  input  logic       i_scl_neg_edge,
  input  logic       i_cccnt_last_frame,
  output logic       o_fcnt_en,
  output logic [5:0] o_bit_count,
  output logic       o_bitcnt_toggle,
  output logic [1:0] o_word_type,
  output logic       o_crc_en,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CMD,
    S_DATA,
    S_CRC,
    S_DONE
  } state_t;

  localparam logic [5:0] WORD_LAST = 6'(WORD_BITS - 1);
  localparam logic [5:0] CRC_LAST  = 6'(CRC_BITS - 1);

  state_t     state_p0;
  state_t     state_nxt;
  logic       scl_edge;
  logic       counting;
  logic       at_limit;
  logic       word_end;
  logic [5:0] bit_cnt_nxt;
  logic       toggle_nxt;

  function automatic logic [5:0] bit_cnt_step(input logic [5:0] cnt, input logic wrap);
    return wrap ? 6'd0 : cnt + 6'd1;
  endfunction

  always_comb begin
    scl_edge = i_scl_pos_edge | i_scl_neg_edge;
    counting = (state_p0 == S_CMD) || (state_p0 == S_DATA) || (state_p0 == S_CRC);
    at_limit = (state_p0 == S_CRC) ? (o_bit_count == CRC_LAST) : (o_bit_count == WORD_LAST);
    word_end = counting && scl_edge && at_limit;
  end

  always_comb begin
    state_nxt = state_p0;
    unique case (state_p0)
      S_IDLE: if (i_fseq_start && !i_fseq_abort) state_nxt = S_LOAD;
      S_LOAD: state_nxt = i_fseq_abort ? S_IDLE : S_CMD;
      S_CMD: begin
        if (i_fseq_abort)  state_nxt = S_IDLE;
        else if (word_end) state_nxt = S_DATA;
      end
      S_DATA: begin
        // last_frame only matters on the edge that closes a data word
        if (i_fseq_abort)                          state_nxt = S_IDLE;
        else if (word_end && i_cccnt_last_frame)   state_nxt = S_CRC;
      end
      S_CRC: begin
        if (i_fseq_abort)  state_nxt = S_IDLE;
        else if (word_end) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_nxt = o_bit_count;
    toggle_nxt  = counting && scl_edge && !i_fseq_abort;
    if (state_nxt != state_p0)       bit_cnt_nxt = 6'd0;
    else if (counting && scl_edge)   bit_cnt_nxt = bit_cnt_step(o_bit_count, at_limit);
  end

  // Outputs are decoded from the next state so every port comes straight from a flop
  always_ff @(posedge i_fseq_clk or negedge i_fseq_rst_n) begin
    if (!i_fseq_rst_n) begin
      state_p0        <= S_IDLE;
      o_fcnt_en       <= 1'b0;
      o_bit_count     <= 6'd0;
      o_bitcnt_toggle <= 1'b0;
      o_word_type     <= 2'b00;
      o_crc_en        <= 1'b0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
    end else begin
      state_p0        <= state_nxt;
      o_bit_count     <= bit_cnt_nxt;
      o_bitcnt_toggle <= toggle_nxt;
      o_fcnt_en       <= (state_nxt == S_DATA) || (state_nxt == S_CRC) || (state_nxt == S_DONE);
      o_crc_en        <= (state_nxt == S_CMD) || (state_nxt == S_DATA);
      o_busy          <= (state_nxt != S_IDLE);
      o_done          <= (state_nxt == S_DONE);
      unique case (state_nxt)
        S_CMD:   o_word_type <= 2'b01;
        S_DATA:  o_word_type <= 2'b10;
        S_CRC:   o_word_type <= 2'b11;
        default: o_word_type <= 2'b00;
      endcase
    end
  end

endmodule

// File: tb/tb_hdr_frame_sequencer.sv
// Self-checking bench for hdr_frame_sequencer: randomized SCL edge streams compared
// against an edge-count arithmetic model of the transfer.
module tb_hdr_frame_sequencer;
  localparam int WB = 20;
  localparam int CB = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       pos = 1'b0;
  logic       neg = 1'b0;
  logic       last = 1'b0;
  logic       fcnt_en;
  logic [5:0] bit_count;
  logic       toggle;
  logic [1:0] word_type;
  logic       crc_en;
  logic       busy;
  logic       done;

  int passed = 0;
  int failed = 0;
  int total = 0;
  int tog_cnt = 0;

  always #5 clk = ~clk;

  hdr_frame_sequencer #(.WORD_BITS(WB), .CRC_BITS(CB)) dut (
    .i_fseq_clk        (clk),
    .i_fseq_rst_n      (rst_n),
    .i_fseq_start      (start),
    .i_fseq_abort      (abort),
    .i_scl_pos_edge    (pos),
    .i_scl_neg_edge    (neg),
    .i_cccnt_last_frame(last),
    .o_fcnt_en         (fcnt_en),
    .o_bit_count       (bit_count),
    .o_bitcnt_toggle   (toggle),
    .o_word_type       (word_type),
    .o_crc_en          (crc_en),
    .o_busy            (busy),
    .o_done            (done)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle === 1'b1) tog_cnt++;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
    chk({tag, "_done"}, {7'd0, done}, 8'd0);
    chk({tag, "_fcnt"}, {7'd0, fcnt_en}, 8'd0);
    chk({tag, "_crc"}, {7'd0, crc_en}, 8'd0);
    chk({tag, "_type"}, {6'd0, word_type}, 8'd0);
    chk({tag, "_bit"}, {2'd0, bit_count}, 8'd0);
  endtask

  // Expected outputs after e counted edges of a transfer with n data words
  task automatic check_state(input int e, input int n, input logic tog);
    int   dend;
    int   tot;
    int   wt;
    int   b;
    logic fe;
    logic ce;
    logic dn;
    dend = WB * (1 + n);
    tot  = dend + CB;
    if (e < WB) begin
      wt = 1; b = e; fe = 1'b0; ce = 1'b1; dn = 1'b0;
    end else if (e < dend) begin
      wt = 2; b = (e - WB) % WB; fe = 1'b1; ce = 1'b1; dn = 1'b0;
    end else if (e < tot) begin
      wt = 3; b = e - dend; fe = 1'b1; ce = 1'b0; dn = 1'b0;
    end else begin
      wt = 0; b = 0; fe = 1'b1; ce = 1'b0; dn = 1'b1;
    end
    if (!dn) chk("word_type", {6'd0, word_type}, 8'(wt));
    chk("bit_count", {2'd0, bit_count}, 8'(b));
    chk("fcnt_en", {7'd0, fcnt_en}, {7'd0, fe});
    chk("crc_en", {7'd0, crc_en}, {7'd0, ce});
    chk("busy", {7'd0, busy}, 8'd1);
    chk("done", {7'd0, done}, {7'd0, dn});
    chk("toggle", {7'd0, toggle}, {7'd0, tog});
  endtask

  // kill_kind: 0 none, 1 abort (with a simultaneous edge), 2 async reset; applied when e == kill_e
  task automatic run_xfer(input int n, input int gap_lo, input int gap_hi, input int kill_e,
                          input int kill_kind, input bit start_in_data, input int rise_bit,
                          input bit both);
    int  e;
    int  dend;
    int  tot;
    int  w;
    int  b;
    int  gap;
    int  k;
    bit  sent;
    dend    = WB * (1 + n);
    tot     = dend + CB;
    sent    = 1'b0;
    tog_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_busy", {7'd0, busy}, 8'd1);
    chk("load_type", {6'd0, word_type}, 8'd0);
    chk("load_fcnt", {7'd0, fcnt_en}, 8'd0);
    chk("load_crc", {7'd0, crc_en}, 8'd0);
    tick();
    check_state(0, n, 1'b0);
    e = 0;
    while (e < tot) begin
      if (e >= WB && e < dend) begin
        w = (e - WB) / WB;
        b = (e - WB) % WB;
        if (w == n - 1) last = (b >= rise_bit);
        else            last = (b != WB - 1) && ($urandom_range(0, 1) == 1);
      end else begin
        last = ($urandom_range(0, 1) == 1);
      end
      if (e == kill_e && kill_kind == 1) begin
        abort = 1'b1; pos = 1'b1; neg = 1'b1;
        tick();
        abort = 1'b0; pos = 1'b0; neg = 1'b0;
        chk_idle("abort");
        tick();
        chk_idle("abort_after");
        return;
      end
      if (e == kill_e && kill_kind == 2) begin
        #2 rst_n = 1'b0;
        #1;
        chk_idle("rst_async");
        chk("rst_async_tog", {7'd0, toggle}, 8'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk_idle("rst_release");
        return;
      end
      gap = $urandom_range(gap_lo, gap_hi);
      for (int g = 0; g < gap; g++) begin
        if (start_in_data && !sent && e >= WB && e < dend) begin
          start = 1'b1;
          sent  = 1'b1;
        end
        tick();
        start = 1'b0;
        check_state(e, n, 1'b0);
      end
      if (both) begin
        pos = 1'b1; neg = 1'b1;
      end else begin
        k = $urandom_range(1, 3);
        pos = k[0]; neg = k[1];
      end
      tick();
      pos = 1'b0; neg = 1'b0;
      e++;
      check_state(e, n, 1'b1);
    end
    last = 1'b0;
    tick();
    chk_idle("end_idle");
    chk("end_tog", {7'd0, toggle}, 8'd0);
    chk("toggle_total", 8'(tog_cnt), 8'(tot));
    if (start_in_data) chk("start_in_data_sent", {7'd0, sent}, 8'd1);
  endtask

  initial begin
    #2;
    chk_idle("por");
    chk("por_tog", {7'd0, toggle}, 8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk_idle("idle0");

    // reset in the middle of DATA at bit 7
    run_xfer(2, 1, 3, WB + 7, 2, 1'b0, 0, 1'b0);
    // one data word, last_frame high throughout data, one edge every 4 clocks
    run_xfer(1, 3, 3, -1, 0, 1'b0, 0, 1'b0);
    // last_frame rises part-way through data word 3
    run_xfer(3, 0, 2, -1, 0, 1'b0, 6, 1'b0);
    // abort at CRC bit 4, then a normal transfer
    run_xfer(1, 0, 2, 2 * WB + 4, 1, 1'b0, 0, 1'b0);
    run_xfer(1, 0, 1, -1, 0, 1'b0, 3, 1'b0);
    // abort coinciding with the command word-end edge
    run_xfer(2, 0, 1, WB - 1, 1, 1'b0, 0, 1'b0);
    // start pulsed during DATA is ignored
    run_xfer(2, 1, 3, -1, 0, 1'b1, 10, 1'b0);
    // both SCL strobes every cycle
    run_xfer(1, 0, 0, -1, 0, 1'b0, 0, 1'b1);

    // start together with abort in IDLE is not accepted
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk_idle("start_abort");
    tick();
    chk_idle("start_abort2");

    for (int r = 0; r < 4; r++) begin
      run_xfer($urandom_range(1, 4), 0, 3, -1, 0, 1'b0, $urandom_range(0, WB - 1), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
